// File: rtl/muldiv_if.sv
// Handshake and result bus for the multiply/divide unit.
// Ports: start/op/a/b launch an operation; whi/wlo/wdata write HI/LO directly;
//        busy/done/hi/lo report status and results back to the pipeline.
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        whi;
    logic        wlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, whi, wlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, whi, wlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
// Latency: done 33 cycles after an accepted start; 2 cycles for divide-by-zero or disabled divide.
// Backpressure: busy=1 while an operation runs; start/whi/wlo are ignored until busy drops.
//
// Ports: clk, rstn (async active-low); bus (muldiv_if.slave): start, op, a, b,
//        whi, wlo, wdata in; busy, done, hi, lo out.
// op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
// Build option: define MULDIV_DIV_EN to include the divider; without it DIV/DIVU
// finish in 2 cycles writing hi=lo=0.
module muldiv_unit (
    input  logic    clk,
    input  logic    rstn,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic        sa_q, sb_q, byp_q;
    logic [5:0]  cnt;
    logic [63:0] acc;      // product accumulator, or {remainder, quotient} for divide
    logic [63:0] wa;       // shifted multiplicand, or divisor in the low word
    logic [31:0] wb;       // multiplier, consumed one bit per step
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic        accept, sgn_in, is_div_in, byp_in, sgn_q;
    logic [31:0] mag_a, mag_b;
    logic [63:0] acc_mul, prod;
    logic [31:0] res_hi, res_lo;

    assign accept    = (state == IDLE) && bus.start;
    assign sgn_in    = ~bus.op[0];
    assign is_div_in = bus.op[1];
    assign mag_a     = (sgn_in && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    assign mag_b     = (sgn_in && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
    assign sgn_q     = ~op_q[0];
    assign acc_mul   = acc + (wb[0] ? wa : 64'd0);

`ifdef MULDIV_DIV_EN
    // Restoring step: shift {rem,quo} left, try subtracting the divisor from the
    // 33-bit shifted remainder, keep the difference when it does not borrow.
    logic [32:0] div_diff;
    logic [63:0] acc_div;
    assign div_diff = acc[63:31] - {1'b0, wa[31:0]};
    assign acc_div  = div_diff[32] ? {acc[62:0], 1'b0}
                                   : {div_diff[31:0], acc[30:0], 1'b1};
    assign byp_in   = is_div_in && (bus.b == 32'd0);
`else
    // Divide ops skip iteration entirely and produce zeros.
    assign byp_in   = is_div_in;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ITER;
            ITER:    if (byp_q || (cnt == 6'd31)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sign fix-up of the unsigned magnitude result.
    always_comb begin
        prod   = (sgn_q && (sa_q ^ sb_q)) ? (64'd0 - acc) : acc;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (op_q[1]) begin
`ifdef MULDIV_DIV_EN
            if (byp_q) begin
                // acc low word still holds |a|; restoring the sign recovers a.
                res_lo = 32'hFFFF_FFFF;
                res_hi = (sgn_q && sa_q) ? (32'd0 - acc[31:0]) : acc[31:0];
            end else begin
                res_lo = (sgn_q && (sa_q ^ sb_q)) ? (32'd0 - acc[31:0])  : acc[31:0];
                res_hi = (sgn_q && sa_q)          ? (32'd0 - acc[63:32]) : acc[63:32];
            end
`else
            res_hi = 32'd0;
            res_lo = 32'd0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q  <= 2'd0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            byp_q <= 1'b0;
            cnt   <= 6'd0;
            acc   <= 64'd0;
            wa    <= 64'd0;
            wb    <= 32'd0;
        end else if (accept) begin
            op_q  <= bus.op;
            sa_q  <= bus.a[31];
            sb_q  <= bus.b[31];
            byp_q <= byp_in;
            cnt   <= 6'd0;
            if (is_div_in) begin
                acc <= {32'd0, mag_a};
                wa  <= {32'd0, mag_b};
                wb  <= 32'd0;
            end else begin
                acc <= 64'd0;
                wa  <= {32'd0, mag_a};
                wb  <= mag_b;
            end
        end else if (state == ITER) begin
            cnt <= cnt + 6'd1;
            if (!byp_q) begin
                if (!op_q[1]) begin
                    acc <= acc_mul;
                    wa  <= {wa[62:0], 1'b0};
                    wb  <= {1'b0, wb[31:1]};
                end
`ifdef MULDIV_DIV_EN
                else begin
                    acc <= acc_div;
                end
`endif
            end
        end
    end

    // HI/LO: direct writes only while idle (same-cycle start is still accepted);
    // the FIX cycle overwrites both with the result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.whi) hi_q <= bus.wdata;
                if (bus.wlo) lo_q <= bus.wdata;
            end else if (state == FIX) begin
                hi_q   <= res_hi;
                lo_q   <= res_lo;
                done_q <= 1'b1;
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; all widths fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only when busy=0.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  multiplicand or dividend, sampled with start.
REQ-007 b  input  32  multiplier or divisor, sampled with start.
REQ-008 whi  input  1  write wdata to HI (MTHI).
REQ-009 wlo  input  1  write wdata to LO (MTLO).
REQ-010 wdata  input  32  data for whi/wlo.
REQ-011 busy  output  1  operation in progress; the pipeline stalls HI/LO consumers while high.
REQ-012 done  output  1  one-cycle pulse when HI/LO receive a new result.
REQ-013 hi  output  32  HI register (product high word or remainder).
REQ-014 lo  output  32  LO register (product low word or quotient).

Function
REQ-015 States SHALL be IDLE, ITER and FIX; IDLE->ITER on an accepted start, ITER->FIX after 32 iteration cycles, FIX->IDLE unconditionally.
REQ-016 An accepted start latches op, |a| and |b| (magnitudes for signed ops, raw for unsigned) and both operand signs, clears the 6-bit iteration counter, and sets busy on the same edge.
REQ-017 ITER SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide, on 64-bit unsigned working registers.
REQ-018 FIX SHALL apply signs for signed ops: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
REQ-019 On the FIX edge: hi/lo are written, done=1 for exactly one cycle, and busy=0; done is visible 33 cycles after the edge that accepted start.
REQ-020 Divide by zero (DIV/DIVU, b=0) SHALL bypass ITER: next edge goes to FIX; lo=32'hFFFFFFFF, hi=a; done follows 2 cycles after acceptance.
REQ-021 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give lo=32'h80000000, hi=0 (no trap).
REQ-022 start, whi and wlo while busy=1 SHALL be ignored; hi/lo hold their prior values until FIX.
REQ-023 In IDLE, whi/wlo write HI/LO on the next edge; whi and wlo together write both.
REQ-024 start and whi/wlo asserted in the same IDLE cycle: the write SHALL take effect and the operation SHALL then start; the FIX result overwrites it.
REQ-025 start is level-sampled: start held high after completion launches a new operation on the first IDLE edge.

Reset
REQ-026 rstn=0 SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, and clear the counter and working registers.
REQ-027 Reset during ITER or FIX SHALL abort the operation with no result written and no done pulse after release.
REQ-028 The first start is accepted on the first rising edge with rstn=1.

Configuration
REQ-029 Macro MULDIV_DIV_EN: when defined, the divider datapath and DIV/DIVU behaviour SHALL be present as specified.
REQ-030 Without MULDIV_DIV_EN: no divider logic SHALL be present; DIV/DIVU SHALL go directly to FIX, write hi=0 and lo=0, and pulse done 2 cycles after acceptance; MULT/MULTU are unchanged.

Verification
REQ-031 MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> after 33 cycles hi=32'hFFFFFFFE, lo=32'h00000001, done pulses once.
REQ-032 MULT a=-3 (32'hFFFFFFFD), b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-033 DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU a=100, b=0 -> lo=32'hFFFFFFFF, hi=100, done at cycle 2.
REQ-034 Mid-operation: start plus whi=1 with wdata=32'h1234 at cycle 10 -> ignored; hi/lo unchanged until FIX; busy stays high.
REQ-035 rstn pulsed low at cycle 20 of MULTU -> hi=lo=0, busy=0 immediately; no done pulse follows.
REQ-036 Back-to-back: start held high -> second operation accepted the cycle after done; its done occurs 33 cycles later.
